// File: rtl/fb_access_arbiter.sv
// Round-robin arbiter sharing the framebuffer random-access port between
// NUM_REQ requesters. One transaction is in flight at a time. The granted
// request is held on the fb_* side until fb_ack_i, or until the watchdog
// aborts it. The result is then returned as a one-cycle req_ack_o pulse.
module fb_access_arbiter #(
  parameter int NUM_REQ        = 3,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                         clk_pix,
  input  logic                         reset_n_i,
  input  logic [NUM_REQ-1:0]           req_sel_i,
  input  logic [NUM_REQ-1:0]           req_wr_i,
  input  logic [4*NUM_REQ-1:0]         req_mask_i,
  input  logic [24*NUM_REQ-1:0]        req_address_i,
  input  logic [16*NUM_REQ-1:0]        req_data_i,
  output logic [NUM_REQ-1:0]           req_ack_o,
  output logic                         req_err_o,
  output logic [15:0]                  req_data_o,
  input  logic                         fb_hold_i,
  output logic                         fb_sel_o,
  output logic                         fb_wr_o,
  output logic [3:0]                   fb_mask_o,
  output logic [23:0]                  fb_address_o,
  output logic [15:0]                  fb_data_o,
  input  logic                         fb_ack_i,
  input  logic [15:0]                  fb_data_i,
  output logic [$clog2(NUM_REQ)-1:0]   grant_o,
  output logic [1:0]                   dbg_state_o
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACCESS = 2'd1, S_RESP = 2'd2} state_t;

  typedef struct packed {
    logic        wr;
    logic [3:0]  mask;
    logic [23:0] addr;
    logic [15:0] data;
  } fb_req_t;

  // Per-requester view of the flattened request buses.
  fb_req_t [NUM_REQ-1:0] lane_req;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    assign lane_req[i] = '{wr:   req_wr_i[i],
                           mask: req_mask_i[4*i +: 4],
                           addr: req_address_i[24*i +: 24],
                           data: req_data_i[16*i +: 16]};
  end

  state_t               state_q, state_d;
  logic [GW-1:0]        ptr_q, ptr_d;
  logic [GW-1:0]        grant_q, grant_d;
  fb_req_t              req_q, req_d;
  logic                 sel_q, sel_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;
  logic                 err_q, err_d;
  logic [15:0]          rdata_q, rdata_d;

  logic                 found;
  logic [GW-1:0]        win;
  logic [GW-1:0]        cand;
  logic                 timeout_hit;

  // Round-robin search. Start one past the last winner and wrap, so the
  // most recently served requester has the lowest priority.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = GW'((int'(ptr_q) + k) % NUM_REQ);
      if (!found && req_sel_i[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  // The watchdog is compiled away when TIMEOUT_CYCLES is 0.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (timer_q == TMO_LAST);

  // Next-state logic for the transaction FSM and all registered outputs.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    req_d   = req_q;
    sel_d   = sel_q;
    timer_d = timer_q;
    ack_d   = ack_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (!fb_hold_i && found) begin
          req_d   = lane_req[win];
          grant_d = win;
          ptr_d   = win;
          sel_d   = 1'b1;
          timer_d = '0;
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        timer_d = timer_q + 1'b1;
        if (fb_ack_i) begin
          sel_d          = 1'b0;
          ack_d          = '0;
          ack_d[grant_q] = 1'b1;
          // A write leaves the last read data on req_data_o.
          if (!req_q.wr) rdata_d = fb_data_i;
          state_d        = S_RESP;
        end else if (timeout_hit) begin
          sel_d          = 1'b0;
          ack_d          = '0;
          ack_d[grant_q] = 1'b1;
          err_d          = 1'b1;
          rdata_d        = 16'h0000;
          state_d        = S_RESP;
        end
      end
      S_RESP: begin
        ack_d   = '0;
        err_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers. An asynchronous reset drops fb_sel_o at once
  // and discards any access that is in flight.
  always_ff @(posedge clk_pix or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= S_IDLE;
      ptr_q   <= GW'(NUM_REQ - 1);
      grant_q <= '0;
      req_q   <= '0;
      sel_q   <= 1'b0;
      timer_q <= '0;
      ack_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      req_q   <= req_d;
      sel_q   <= sel_d;
      timer_q <= timer_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  assign fb_sel_o     = sel_q;
  assign fb_wr_o      = req_q.wr;
  assign fb_mask_o    = req_q.mask;
  assign fb_address_o = req_q.addr;
  assign fb_data_o    = req_q.data;
  assign req_ack_o    = ack_q;
  assign req_err_o    = err_q;
  assign req_data_o   = rdata_q;
  assign grant_o      = grant_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_fb_access_arbiter.sv
// Directed and randomized bench for fb_access_arbiter. A round-robin
// reference model predicts each winner. Each access is checked against the
// fields the bench drove, and the response against a model of req_data_o.
module tb_fb_access_arbiter;
  localparam int N   = 3;
  localparam int TMO = 16;

  logic              clk_pix = 1'b0;
  logic              reset_n_i;
  logic [N-1:0]      req_sel_i;
  logic [N-1:0]      req_wr_i;
  logic [4*N-1:0]    req_mask_i;
  logic [24*N-1:0]   req_address_i;
  logic [16*N-1:0]   req_data_i;
  logic [N-1:0]      req_ack_o;
  logic              req_err_o;
  logic [15:0]       req_data_o;
  logic              fb_hold_i;
  logic              fb_sel_o;
  logic              fb_wr_o;
  logic [3:0]        fb_mask_o;
  logic [23:0]       fb_address_o;
  logic [15:0]       fb_data_o;
  logic              fb_ack_i;
  logic [15:0]       fb_data_i;
  logic [$clog2(N)-1:0] grant_o;
  logic [1:0]        dbg_state_o;

  fb_access_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_pix(clk_pix), .reset_n_i(reset_n_i),
    .req_sel_i(req_sel_i), .req_wr_i(req_wr_i), .req_mask_i(req_mask_i),
    .req_address_i(req_address_i), .req_data_i(req_data_i),
    .req_ack_o(req_ack_o), .req_err_o(req_err_o), .req_data_o(req_data_o),
    .fb_hold_i(fb_hold_i), .fb_sel_o(fb_sel_o), .fb_wr_o(fb_wr_o),
    .fb_mask_o(fb_mask_o), .fb_address_o(fb_address_o), .fb_data_o(fb_data_o),
    .fb_ack_i(fb_ack_i), .fb_data_i(fb_data_i),
    .grant_o(grant_o), .dbg_state_o(dbg_state_o)
  );

  always #5 clk_pix = ~clk_pix;

  int nchecks = 0;
  int nerr    = 0;

  // Reference model state: the last winner and the expected req_data_o.
  int          m_last;
  logic [15:0] m_rdata;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchecks++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_pix);
    #1;
  endtask

  task automatic set_req(input int i, input logic wr, input logic [3:0] m,
                         input logic [23:0] a, input logic [15:0] d);
    req_wr_i[i]               = wr;
    req_mask_i[4*i +: 4]      = m;
    req_address_i[24*i +: 24] = a;
    req_data_i[16*i +: 16]    = d;
    req_sel_i[i]              = 1'b1;
  endtask

  // First pending requester after the last winner, with wraparound.
  function automatic int pick(input logic [N-1:0] s, input int last);
    for (int k = 1; k <= N; k++)
      if (s[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  // Wait for the grant and check the fb_* side. Then ack after dly cycles,
  // or let the watchdog fire. Check the response pulse and the return to IDLE.
  task automatic serve(input int dly, input logic [15:0] rd, input bit tmo,
                       input bit keep, input bit hold_mid, output int w);
    int waited;
    waited = 0;
    w = pick(req_sel_i, m_last);
    while (!fb_sel_o && waited < 10) begin cyc(); waited++; end
    chk("grant_wait", fb_sel_o, 1);
    chk("grant_idx", grant_o, w);
    chk("fb_wr", fb_wr_o, req_wr_i[w]);
    chk("fb_mask", fb_mask_o, req_mask_i[4*w +: 4]);
    chk("fb_addr", fb_address_o, req_address_i[24*w +: 24]);
    chk("fb_data", fb_data_o, req_data_i[16*w +: 16]);
    chk("state_access", dbg_state_o, 1);
    m_last = w;
    fb_hold_i = hold_mid;
    if (!tmo) begin
      repeat (dly) cyc();
      chk("sel_held", fb_sel_o, 1);
      fb_ack_i  = 1'b1;
      fb_data_i = rd;
      cyc();
      fb_ack_i  = 1'b0;
      fb_data_i = 16'($urandom);
      if (!req_wr_i[w]) m_rdata = rd;
    end else begin
      repeat (TMO - 1) cyc();
      chk("tmo_still_access", fb_sel_o, 1);
      chk("tmo_no_early_ack", req_ack_o, 0);
      cyc();
      m_rdata = 16'h0000;
    end
    chk("ack", req_ack_o, 64'(1) << w);
    chk("err", req_err_o, tmo);
    chk("sel_drop", fb_sel_o, 0);
    chk("rdata", req_data_o, m_rdata);
    chk("state_resp", dbg_state_o, 2);
    if (!keep) req_sel_i[w] = 1'b0;
    cyc();
    chk("ack_clr", {req_err_o, req_ack_o}, 0);
    chk("state_idle", dbg_state_o, 0);
  endtask

  initial begin
    int w;
    reset_n_i = 1'b0; req_sel_i = '0; req_wr_i = '0; req_mask_i = '0;
    req_address_i = '0; req_data_i = '0; fb_hold_i = 1'b0;
    fb_ack_i = 1'b0; fb_data_i = '0;
    m_last = N - 1; m_rdata = 16'h0000;

    // Reset values
    #12;
    chk("rst_sel", fb_sel_o, 0);
    chk("rst_ack", {req_err_o, req_ack_o}, 0);
    chk("rst_rdata", req_data_o, 0);
    chk("rst_grant", grant_o, 0);
    chk("rst_state", dbg_state_o, 0);
    chk("rst_fb", {fb_wr_o, fb_mask_o, fb_address_o, fb_data_o}, 0);
    cyc(); cyc();
    reset_n_i = 1'b1;

    // Single write from requester 0
    set_req(0, 1'b1, 4'hF, 24'h000100, 16'hBEEF);
    serve(4, 16'h5555, 0, 0, 0, w);

    // Read from requester 2
    set_req(2, 1'b0, 4'h3, 24'h000010, 16'h0000);
    serve(2, 16'h1234, 0, 0, 0, w);

    // Round-robin with all three requesters held high
    set_req(0, 1'b1, 4'h1, 24'h0000A0, 16'h1111);
    set_req(1, 1'b0, 4'h2, 24'h0000B0, 16'h2222);
    set_req(2, 1'b1, 4'h4, 24'h0000C0, 16'h3333);
    for (int k = 0; k < 6; k++) serve(1, 16'(16'hA000 + k), 0, 1, 0, w);
    req_sel_i = '0;

    // Hold blocks new grants, and the grant comes one cycle after release
    fb_hold_i = 1'b1;
    set_req(1, 1'b0, 4'hF, 24'h123456, 16'h0);
    for (int k = 0; k < 20; k++) begin cyc(); chk("hold_idle", fb_sel_o, 0); end
    fb_hold_i = 1'b0;
    cyc();
    chk("hold_release", fb_sel_o, 1);
    serve(3, 16'h4321, 0, 0, 0, w);

    // Hold raised during ACCESS does not stop the access
    set_req(0, 1'b0, 4'h5, 24'h00ABCD, 16'h0);
    serve(3, 16'h0F0F, 0, 0, 1, w);
    fb_hold_i = 1'b0;

    // Watchdog timeout, then a late ack and an idle ack are ignored
    set_req(1, 1'b0, 4'hA, 24'h0DEAD0, 16'h0);
    serve(0, 16'h0, 1, 0, 0, w);
    fb_ack_i = 1'b1; fb_data_i = 16'hDEAD;
    cyc();
    fb_ack_i = 1'b0;
    chk("late_ack_ignored", req_ack_o, 0);
    chk("late_ack_data", req_data_o, m_rdata);
    cyc();
    chk("late_ack_idle", dbg_state_o, 0);

    // Reset asserted mid-ACCESS
    set_req(2, 1'b1, 4'hC, 24'h00FFFF, 16'h7777);
    cyc();
    chk("pre_rst_access", fb_sel_o, 1);
    #2 reset_n_i = 1'b0;
    #1;
    chk("async_rst_sel", fb_sel_o, 0);
    chk("async_rst_ack", req_ack_o, 0);
    chk("async_rst_state", dbg_state_o, 0);
    m_last = N - 1; m_rdata = 16'h0000;
    set_req(0, 1'b0, 4'h9, 24'h000200, 16'h0);
    set_req(1, 1'b1, 4'h6, 24'h000300, 16'h8888);
    cyc();
    reset_n_i = 1'b1;
    serve(1, 16'h6543, 0, 0, 0, w);
    chk("post_rst_first", w, 0);
    req_sel_i = '0;

    // Randomized traffic checked against the round-robin model
    for (int it = 0; it < 40; it++) begin
      for (int i = 0; i < N; i++)
        if (!req_sel_i[i] && $urandom_range(0, 1) == 1)
          set_req(i, 1'($urandom_range(0, 1)), 4'($urandom), 24'($urandom), 16'($urandom));
      if (req_sel_i == '0)
        set_req(int'($urandom_range(0, N - 1)), 1'($urandom_range(0, 1)), 4'($urandom),
                24'($urandom), 16'($urandom));
      serve(int'($urandom_range(0, 6)), 16'($urandom), 0,
            $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0, w);
      fb_hold_i = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

  // Absolute bound so the run always ends
  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
